uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter. It serialises DBIT-wide words LSB-first with optional even/odd parity and 1, 1.5 or 2 stop bits. An internal baud-tick generator is driven by a runtime divisor, and words are accepted over a ready/valid handshake. It sits between the host-side command/data path and the serial pin, and supersedes the fixed 8N1 transmitter in new designs.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_tx_cfg_if.sv | 9 +
 rtl/uart_baud_gen.sv | 23 ++
 rtl/uart_tx_cfg.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and encodings for the configurable UART transmitter.
// UART_TX_BREAK_EN adds the BREAK state to the state enum.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
`ifdef UART_TX_BREAK_EN
      , ST_BREAK
`endif
   } state_t;

   localparam int OVERSAMPLE = 16;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   localparam logic [1:0] STOP_1   = 2'd0;
   localparam logic [1:0] STOP_1P5 = 2'd1;
   localparam logic [1:0] STOP_2   = 2'd2;

   localparam int STOP_TICKS_1   = 16;
   localparam int STOP_TICKS_1P5 = 24;
   localparam int STOP_TICKS_2   = 32;

   // Index of the final tick of the stop period (encoding 3 behaves as 2 stop bits).
   function automatic logic [4:0] stop_last(input logic [1:0] sel);
      case (sel)
         STOP_1:   return 5'(STOP_TICKS_1 - 1);
         STOP_1P5: return 5'(STOP_TICKS_1P5 - 1);
         default:  return 5'(STOP_TICKS_2 - 1);
      endcase
   endfunction

   function automatic logic par_on(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side word handshake for the UART transmitter.
interface uart_tx_cfg_if #(parameter int DBIT = 8);
   logic [DBIT-1:0] tx_din;
   logic            tx_valid;
   logic            tx_ready;

   modport master (output tx_din, output tx_valid, input tx_ready);
   modport slave  (input tx_din, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one tick every dvsr+1 clocks, restartable via clr.
module uart_baud_gen #(
   parameter int DVSR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [DVSR_W-1:0] dvsr,
   output logic              tick
);
   logic [DVSR_W-1:0] cnt;

   assign tick = (cnt == dvsr);

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (DBIT data bits, optional parity, 1/1.5/2 stop).
// Define UART_TX_BREAK_EN to add the tx_break port and line-break generation.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DBIT   = 8,
   parameter int DVSR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic [1:0]        parity_mode,
   input  logic [1:0]        stop_sel,
`ifdef UART_TX_BREAK_EN
   input  logic              tx_break,
`endif
   uart_tx_cfg_if.slave      host,
   output logic              tx_busy,
   output logic              tx_done_tick,
   output logic              tx
);
   localparam int BW = $clog2(DBIT + 1);

   state_t            state;
   logic [DBIT-1:0]   shreg;
   logic [DBIT-1:0]   data_l;
   logic [1:0]        par_l;
   logic [1:0]        stop_l;
   logic [DVSR_W-1:0] dvsr_l;
   logic [4:0]        tcnt;
   logic [BW-1:0]     bcnt;
   logic              tick;
   logic              clr;
   logic              bit_end;
   logic              stop_end;
   logic              par_bit;
`ifdef UART_TX_BREAK_EN
   logic              brk_rel;
`endif

   assign host.tx_ready = (state == ST_IDLE);
   assign tx_busy       = (state != ST_IDLE);

   assign bit_end  = tick && (tcnt == 5'(OVERSAMPLE - 1));
   assign stop_end = tick && (tcnt == stop_last(stop_l));
   assign par_bit  = (par_l == PAR_ODD) ? ~^data_l : ^data_l;

   // Done coincides with the final stop tick; the state register returns to IDLE on that edge.
   assign tx_done_tick = (state == ST_STOP) && stop_end;

   // Baud counter held at zero while idle so every frame starts on a fresh tick phase.
   always_comb begin
      clr = (state == ST_IDLE);
`ifdef UART_TX_BREAK_EN
      if (state == ST_BREAK && !brk_rel)
         clr = 1'b1;
`endif
   end

   uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .dvsr  (dvsr_l),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         tx     <= 1'b1;
         shreg  <= '0;
         data_l <= '0;
         par_l  <= PAR_NONE;
         stop_l <= STOP_1;
         dvsr_l <= '0;
         tcnt   <= '0;
         bcnt   <= '0;
`ifdef UART_TX_BREAK_EN
         brk_rel <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               tx <= 1'b1;
`ifdef UART_TX_BREAK_EN
               if (tx_break) begin
                  dvsr_l  <= dvsr;
                  tcnt    <= '0;
                  brk_rel <= 1'b0;
                  state   <= ST_BREAK;
               end else
`endif
               if (host.tx_valid) begin
                  shreg  <= host.tx_din;
                  data_l <= host.tx_din;
                  par_l  <= parity_mode;
                  stop_l <= stop_sel;
                  dvsr_l <= dvsr;
                  tcnt   <= '0;
                  bcnt   <= '0;
                  state  <= ST_START;
               end
            end
            ST_START: begin
               tx <= 1'b0;
               if (bit_end) begin
                  tcnt  <= '0;
                  state <= ST_DATA;
               end else if (tick)
                  tcnt <= tcnt + 5'd1;
            end
            ST_DATA: begin
               tx <= shreg[0];
               if (bit_end) begin
                  tcnt  <= '0;
                  shreg <= shreg >> 1;
                  if (bcnt == BW'(DBIT - 1)) begin
                     bcnt  <= '0;
                     state <= par_on(par_l) ? ST_PARITY : ST_STOP;
                  end else
                     bcnt <= bcnt + 1'b1;
               end else if (tick)
                  tcnt <= tcnt + 5'd1;
            end
            ST_PARITY: begin
               tx <= par_bit;
               if (bit_end) begin
                  tcnt  <= '0;
                  state <= ST_STOP;
               end else if (tick)
                  tcnt <= tcnt + 5'd1;
            end
            ST_STOP: begin
               tx <= 1'b1;
               if (stop_end) begin
                  tcnt  <= '0;
                  state <= ST_IDLE;
               end else if (tick)
                  tcnt <= tcnt + 5'd1;
            end
`ifdef UART_TX_BREAK_EN
            // Line held low while requested, then one bit-time of mark before idle.
            ST_BREAK: begin
               if (!brk_rel) begin
                  tx   <= 1'b0;
                  tcnt <= '0;
                  if (!tx_break)
                     brk_rel <= 1'b1;
               end else begin
                  tx <= 1'b1;
                  if (bit_end) begin
                     tcnt    <= '0;
                     brk_rel <= 1'b0;
                     state   <= ST_IDLE;
                  end else if (tick)
                     tcnt <= tcnt + 5'd1;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (DBIT=8); break test runs when UART_TX_BREAK_EN is defined.
module tb_uart_tx_cfg;
   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] dvsr;
   logic [1:0]  parity_mode;
   logic [1:0]  stop_sel;
   logic        tx_busy, tx_done_tick, tx;
`ifdef UART_TX_BREAK_EN
   logic        tx_break;
`endif

   int total = 0;
   int bad   = 0;

   logic tx_h   [0:1023];
   logic busy_h [0:1023];
   int   blen, dcnt, didx;

   uart_tx_cfg_if #(.DBIT(8)) bus ();

   uart_tx_cfg #(.DBIT(8), .DVSR_W(11)) dut (
      .clk          (clk),
      .reset        (reset),
      .dvsr         (dvsr),
      .parity_mode  (parity_mode),
      .stop_sel     (stop_sel),
`ifdef UART_TX_BREAK_EN
      .tx_break     (tx_break),
`endif
      .host         (bus),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick),
      .tx           (tx)
   );

   always #5 clk = ~clk;

   // Sample index i holds outputs #1 after the i-th edge following the accept edge (index 0).
   task automatic run_frame(input logic [7:0] din, input logic [1:0] par, input logic [1:0] stp,
                            input logic [10:0] dv, input int lim);
      int i;
      bus.tx_din = din; parity_mode = par; stop_sel = stp; dvsr = dv; bus.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      bus.tx_din = ~din;
      parity_mode = (par == 2'd0) ? 2'd1 : 2'd0;
      stop_sel = (stp == 2'd0) ? 2'd2 : 2'd0;
      dvsr = dv + 11'd5;
      i = 0; dcnt = 0; didx = -1;
      tx_h[0] = tx; busy_h[0] = tx_busy;
      if (tx_done_tick) begin dcnt++; didx = 0; end
      while (busy_h[i] && i < lim) begin
         @(posedge clk); #1;
         i++;
         tx_h[i] = tx; busy_h[i] = tx_busy;
         if (tx_done_tick) begin dcnt++; didx = i; end
      end
      blen = i;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.tx_valid = 1'b1; bus.tx_din = 8'h55;
      dvsr = 11'd0; parity_mode = 2'd0; stop_sel = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got %b want 1", tx); end
      total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.tx_ready); end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", tx_busy); end
      total++; if (tx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", tx_done_tick); end
      reset = 1'b0; bus.tx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_no_accept busy got %b want 0", tx_busy); end
   endtask

   task automatic test_8n1();
      bit seq [10] = '{0,1,0,1,0,0,1,0,1,1};
      int err;
      run_frame(8'hA5, 2'd0, 2'd0, 11'd1, 1000);
      total++; if (tx_h[0] !== 1'b1) begin bad++; $display("FAIL 8n1_accept_edge_tx got %b want 1", tx_h[0]); end
      for (int b = 0; b < 10; b++) begin
         err = 0;
         for (int k = 1 + b*32; k <= 32 + b*32; k++) if (tx_h[k] !== seq[b]) err++;
         total++; if (err != 0) begin bad++; $display("FAIL 8n1_bit%0d wrong_samples=%0d want level %0d", b, err, seq[b]); end
      end
      total++; if (blen != 320) begin bad++; $display("FAIL 8n1_len got %0d want 320", blen); end
      total++; if (dcnt != 1) begin bad++; $display("FAIL 8n1_done_count got %0d want 1", dcnt); end
      total++; if (didx != 319) begin bad++; $display("FAIL 8n1_done_pos got %0d want 319", didx); end
   endtask

   task automatic test_parity();
      bit seq_e [11] = '{0,1,0,1,0,0,1,0,1,0,1};
      bit seq_o [11] = '{0,1,0,1,0,0,1,0,1,1,1};
      int err;
      run_frame(8'hA5, 2'd1, 2'd0, 11'd1, 1000);
      for (int b = 0; b < 11; b++) begin
         err = 0;
         for (int k = 1 + b*32; k <= 32 + b*32; k++) if (tx_h[k] !== seq_e[b]) err++;
         total++; if (err != 0) begin bad++; $display("FAIL even_bit%0d wrong_samples=%0d want level %0d", b, err, seq_e[b]); end
      end
      total++; if (blen != 352) begin bad++; $display("FAIL even_len got %0d want 352", blen); end
      run_frame(8'hA5, 2'd2, 2'd0, 11'd1, 1000);
      err = 0;
      for (int k = 289; k <= 320; k++) if (tx_h[k] !== 1'b1) err++;
      total++; if (err != 0) begin bad++; $display("FAIL odd_parity wrong_samples=%0d want level 1", err); end
      err = 0;
      for (int k = 0; k < 11; k++) if (tx_h[1 + k*32 + 16] !== seq_o[k]) err++;
      total++; if (err != 0) begin bad++; $display("FAIL odd_frame wrong_bits=%0d want 0", err); end
      total++; if (blen != 352) begin bad++; $display("FAIL odd_len got %0d want 352", blen); end
      total++; if (dcnt != 1) begin bad++; $display("FAIL odd_done_count got %0d want 1", dcnt); end
   endtask

   task automatic test_stop_1p5();
      int highs;
      run_frame(8'h3C, 2'd0, 2'd1, 11'd0, 1000);
      highs = 0;
      for (int k = 145; k <= 168; k++) if (tx_h[k] === 1'b1) highs++;
      total++; if (tx_h[144] !== 1'b0) begin bad++; $display("FAIL s15_last_data got %b want 0", tx_h[144]); end
      total++; if (highs != 24) begin bad++; $display("FAIL s15_stop_high got %0d want 24", highs); end
      total++; if (blen != 168) begin bad++; $display("FAIL s15_len got %0d want 168", blen); end
      total++; if (didx != 167) begin bad++; $display("FAIL s15_done_pos got %0d want 167", didx); end
   endtask

   task automatic test_back_to_back();
      int rises, r2, dn;
      logic prev;
      bus.tx_din = 8'h01; dvsr = 11'd0; parity_mode = 2'd0; stop_sel = 2'd0; bus.tx_valid = 1'b1;
      prev = 1'b0; rises = 0; r2 = -1; dn = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         tx_h[i] = tx; busy_h[i] = tx_busy;
         if (tx_done_tick) dn++;
         if (tx_busy && !prev) begin
            rises++;
            if (rises == 1) bus.tx_din = 8'h80;
            else begin bus.tx_valid = 1'b0; r2 = i; end
         end
         prev = tx_busy;
      end
      total++; if (rises != 2) begin bad++; $display("FAIL b2b_accepts got %0d want 2", rises); end
      total++; if (r2 != 161) begin bad++; $display("FAIL b2b_second_accept got %0d want 161", r2); end
      total++; if (dn != 2) begin bad++; $display("FAIL b2b_done_count got %0d want 2", dn); end
      total++; if (busy_h[160] !== 1'b0) begin bad++; $display("FAIL b2b_ready_cycle busy got %b want 0", busy_h[160]); end
      total++; if (tx_h[162] !== 1'b0) begin bad++; $display("FAIL b2b_start2 got %b want 0", tx_h[162]); end
      total++; if ({tx_h[25], tx_h[137]} !== 2'b10) begin bad++; $display("FAIL b2b_word1 got %b%b want 10", tx_h[25], tx_h[137]); end
      total++; if ({tx_h[186], tx_h[298]} !== 2'b01) begin bad++; $display("FAIL b2b_word2 got %b%b want 01", tx_h[186], tx_h[298]); end
   endtask

   task automatic test_reset_mid_frame();
      bit seq [10] = '{0,0,1,0,1,1,0,1,0,1};
      int dn, err;
      bus.tx_din = 8'h5A; dvsr = 11'd1; parity_mode = 2'd0; stop_sel = 2'd0; bus.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      dn = 0;
      repeat (100) begin @(posedge clk); #1; if (tx_done_tick) dn++; end
      reset = 1'b1;
      @(posedge clk); #1;
      if (tx_done_tick) dn++;
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx got %b want 1", tx); end
      total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got %b want 1", bus.tx_ready); end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", tx_busy); end
      reset = 1'b0;
      @(posedge clk); #1;
      total++; if (dn != 0) begin bad++; $display("FAIL midrst_no_done got %0d want 0", dn); end
      run_frame(8'h5A, 2'd0, 2'd0, 11'd1, 1000);
      err = 0;
      for (int b = 0; b < 10; b++)
         for (int k = 1 + b*32; k <= 32 + b*32; k++) if (tx_h[k] !== seq[b]) err++;
      total++; if (err != 0) begin bad++; $display("FAIL midrst_refresh wrong_samples=%0d want 0", err); end
      total++; if (blen != 320) begin bad++; $display("FAIL midrst_len got %0d want 320", blen); end
      total++; if (dcnt != 1) begin bad++; $display("FAIL midrst_done got %0d want 1", dcnt); end
   endtask

`ifdef UART_TX_BREAK_EN
   task automatic test_break();
      int lows, dn, back;
      dvsr = 11'd0; bus.tx_valid = 1'b0; tx_break = 1'b1;
      lows = 0; dn = 0; back = -1;
      for (int k = 1; k <= 140; k++) begin
         @(posedge clk); #1;
         if (k == 100) tx_break = 1'b0;
         if (tx === 1'b0) lows++;
         if (tx_done_tick) dn++;
         if (k == 101 && tx !== 1'b0) lows = -1000;
         if (back < 0 && !tx_busy) back = k;
      end
      total++; if (lows != 100) begin bad++; $display("FAIL brk_low got %0d want 100", lows); end
      total++; if (back != 117) begin bad++; $display("FAIL brk_idle_pos got %0d want 117", back); end
      total++; if (dn != 0) begin bad++; $display("FAIL brk_done got %0d want 0", dn); end
   endtask
`endif

   initial begin
`ifdef UART_TX_BREAK_EN
      tx_break = 1'b0;
`endif
      test_reset();
      test_8n1();
      test_parity();
      test_stop_1p5();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
      test_break();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
